// File: rtl/shift_sequencer.sv
// Multi-position shift controller: feeds an external single-bit shifter once per
// clock, recirculating its output until the requested count has been shifted.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [CNT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [WIDTH-1:0] sh_a,
  output logic             sh_la,
  output logic             sh_lr,
  input  logic [WIDTH-1:0] sh_y,
  input  logic             sh_c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             carry_q, carry_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = a_in;
          cnt_d   = amt;
          mode_d  = mode;
          carry_d = 1'b0;
          state_d = (amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_d  = sh_y;
        carry_d = sh_c;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reserved mode 11 folds onto arithmetic right because only mode_q[1] selects LA.
  assign sh_la  = mode_q[1];
  assign sh_lr  = ~mode_q[1] & mode_q[0];
  assign sh_a   = work_q;
  assign result = work_q;
  assign carry  = carry_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule
